// File: rtl/scie_pipelined_fir.sv
// -----------------------------------------------------------------------------
// scie_pipelined_fir
//
// Pipelined 5-tap FIR functional unit for the core's custom-opcode interface.
// Software loads coefficients (SETCOEF), shifts samples into a delay line
// (PUSH), and latches the filter output into io_rd (READ). One instruction is
// accepted every cycle; there is no back-pressure.
//
// Pipeline:
//   state  : coef_reg / tap_reg, written by SETCOEF / PUSH
//   stage 1: prod_reg[i] <= tap_reg[i] * coef_reg[i] (every cycle)
//   stage 2: io_rd       <= sum(prod_reg)            (on READ only)
// A READ therefore observes PUSH/SETCOEF effects only from two edges later.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-low reset (0 clears all state)
//   io_valid  in   instruction valid this cycle
//   io_insn   in   instruction word, only [6:0] decoded
//   io_rs1    in   operand 1 (coefficient value or sample)
//   io_rs2    in   operand 2 (coefficient index for SETCOEF)
//   io_rd     out  registered filter result
// -----------------------------------------------------------------------------
module scie_pipelined_fir #(
  parameter int XLEN  = 32,
  parameter int NTAPS = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;

  logic [6:0]      opcode;
  logic            is_setcoef;
  logic            is_push;
  logic            is_read;

  logic [XLEN-1:0] coef_reg [NTAPS];
  logic [XLEN-1:0] tap_reg  [NTAPS];
  logic [XLEN-1:0] prod_reg [NTAPS];
  logic [XLEN-1:0] sum_next;
  logic [XLEN-1:0] rd_reg;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign opcode     = io_insn[6:0];
  assign is_setcoef = io_valid && (opcode == OP_SETCOEF);
  assign is_push    = io_valid && (opcode == OP_PUSH);
  assign is_read    = io_valid && (opcode == OP_READ);

  // ---------------------------------------------------------------------------
  // Coefficient bank. The index is compared at full operand width so that any
  // index >= NTAPS simply matches no slot and the write is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_reg[i] <= '0;
      end
    end else if (is_setcoef) begin
      for (int i = 0; i < NTAPS; i++) begin
        if (io_rs2 == XLEN'(i)) begin
          coef_reg[i] <= io_rs1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample delay line: newest sample enters tap 0, oldest falls off the end.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        tap_reg[i] <= '0;
      end
    end else if (is_push) begin
      tap_reg[0] <= io_rs1;
      for (int i = 1; i < NTAPS; i++) begin
        tap_reg[i] <= tap_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-tap products, recomputed every cycle. Only the low XLEN bits
  // are kept since the final sum wraps mod 2^XLEN anyway.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        prod_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        prod_reg[i] <= tap_reg[i] * coef_reg[i];
      end
    end
  end

  // Adder across the registered products; wraps mod 2^XLEN.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum_next = sum_next + prod_reg[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result register, loaded on READ and held otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_reg <= '0;
    end else if (is_read) begin
      rd_reg <= sum_next;
    end
  end

  assign io_rd = rd_reg;

endmodule

// File: tb/tb_scie_pipelined_fir.sv
module tb_scie_pipelined_fir;

  localparam int XLEN  = 32;
  localparam int NTAPS = 5;

  localparam logic [6:0] OP_SETCOEF = 7'h0B;
  localparam logic [6:0] OP_PUSH    = 7'h2B;
  localparam logic [6:0] OP_READ    = 7'h5B;
  localparam logic [6:0] OP_OTHER   = 7'h7B;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            io_valid = 1'b0;
  logic [31:0]     io_insn = '0;
  logic [XLEN-1:0] io_rs1 = '0;
  logic [XLEN-1:0] io_rs2 = '0;
  logic [XLEN-1:0] io_rd;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  scie_pipelined_fir #(.XLEN(XLEN), .NTAPS(NTAPS)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_valid (io_valid),
    .io_insn  (io_insn),
    .io_rs1   (io_rs1),
    .io_rs2   (io_rs2),
    .io_rd    (io_rd)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the architectural coefficient and sample arrays, plus the
  // rule that a READ sees the filter output of the state as it stood two edges
  // earlier (kept as a short queue of past dot products).
  // ---------------------------------------------------------------------------
  logic [31:0] m_coef [NTAPS];
  logic [31:0] m_tap  [NTAPS];
  logic [31:0] m_rd = '0;
  logic [31:0] seen_sum [$];

  function automatic logic [31:0] dot_product();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NTAPS; i++) begin
      s = s + m_coef[i] * m_tap[i];
    end
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      m_coef[i] = '0;
      m_tap[i]  = '0;
    end
    m_rd = '0;
    seen_sum = {32'd0, 32'd0};
  endfunction

  // One clock cycle of stimulus; inputs change on the falling edge, the model
  // advances at the rising edge, outputs are sampled 1 time unit later.
  task automatic step(input logic rst_n, input logic v, input logic [6:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    reset    = rst_n;
    io_valid = v;
    io_insn  = {25'($urandom), op};
    io_rs1   = a;
    io_rs2   = b;
    @(posedge clock);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (v && op == OP_READ) m_rd = seen_sum[0];
      if (v && op == OP_SETCOEF && b < NTAPS) m_coef[b] = a;
      if (v && op == OP_PUSH) begin
        for (int i = NTAPS - 1; i > 0; i--) m_tap[i] = m_tap[i-1];
        m_tap[0] = a;
      end
      void'(seen_sum.pop_front());
      seen_sum.push_back(dot_product());
    end
    #1;
    if (!rst_n || v)
      $display("txn rst_n=%0b valid=%0b op=0x%02h rs1=0x%08h rs2=0x%08h rd=0x%08h",
               rst_n, v, op, a, b, io_rd);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, OP_READ, 32'd0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    step(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    step(1'b0, 1'b1, OP_READ, 32'd0, 32'd0);
    idle();
    total++;
    if (io_rd !== 32'd0) begin
      bad++;
      $display("FAIL reset_rd got=0x%08h want=0x%08h", io_rd, 32'd0);
    end
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd0) begin
      bad++;
      $display("FAIL reset_read got=0x%08h want=0x%08h", io_rd, 32'd0);
    end
  endtask

  task automatic test_coef_load();
    logic [31:0] coefs [NTAPS];
    coefs = '{32'd33, 32'd32, 32'd57, 32'd47, 32'd94};
    for (int i = 0; i < NTAPS; i++) step(1'b1, 1'b1, OP_SETCOEF, coefs[i], 32'(i));
    step(1'b1, 1'b1, OP_PUSH, 32'd50, 32'd0);
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd1650) begin
      bad++;
      $display("FAIL first_sample got=%0d want=%0d", io_rd, 1650);
    end
  endtask

  task automatic test_hazard();
    step(1'b1, 1'b1, OP_PUSH, 32'd92, 32'd0);
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd1650) begin
      bad++;
      $display("FAIL hazard_early_read got=%0d want=%0d", io_rd, 1650);
    end
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd4636) begin
      bad++;
      $display("FAIL hazard_late_read got=%0d want=%0d", io_rd, 4636);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      total++;
      if (io_rd !== 32'd4636) begin
        bad++;
        $display("FAIL hold_idle%0d got=%0d want=%0d", k, io_rd, 4636);
      end
    end
  endtask

  task automatic test_fir_sequence();
    logic [31:0] samples [3];
    logic [31:0] want [3];
    samples = '{32'd58, 32'd64, 32'd40};
    want    = '{32'd7708, 32'd11562, 32'd15698};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, OP_PUSH, samples[k], 32'd0);
      idle();
      step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
      total++;
      if (io_rd !== want[k]) begin
        bad++;
        $display("FAIL fir_sample%0d got=%0d want=%0d", k, io_rd, want[k]);
      end
    end
  endtask

  task automatic test_edge_cases();
    step(1'b1, 1'b1, OP_SETCOEF, 32'd999, 32'd7);
    idle();
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd15698) begin
      bad++;
      $display("FAIL setcoef_out_of_range got=%0d want=%0d", io_rd, 15698);
    end
    step(1'b1, 1'b1, OP_OTHER, 32'd12345, 32'd1);
    idle();
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd15698) begin
      bad++;
      $display("FAIL unknown_opcode got=%0d want=%0d", io_rd, 15698);
    end
    // A valid-low PUSH must not shift the delay line.
    step(1'b1, 1'b0, OP_PUSH, 32'd1000, 32'd0);
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd15698) begin
      bad++;
      $display("FAIL invalid_push got=%0d want=%0d", io_rd, 15698);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, OP_PUSH, 32'd77, 32'd0);
    total++;
    if (io_rd !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_rd got=%0d want=%0d", io_rd, 0);
    end
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_prod got=%0d want=%0d", io_rd, 0);
    end
    step(1'b1, 1'b1, OP_PUSH, 32'd5, 32'd0);
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_coef got=%0d want=%0d", io_rd, 0);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b1, OP_SETCOEF, 32'hFFFF_FFFF, 32'd0);
    step(1'b1, 1'b1, OP_PUSH, 32'd2, 32'd0);
    idle();
    step(1'b1, 1'b1, OP_READ, 32'd0, 32'd0);
    total++;
    if (io_rd !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL wrap got=0x%08h want=0x%08h", io_rd, 32'hFFFF_FFFE);
    end
  endtask

  task automatic test_random();
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic        r;
    step(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 4))
        0:       op = OP_SETCOEF;
        1:       op = OP_PUSH;
        2, 3:    op = OP_READ;
        default: op = OP_OTHER;
      endcase
      v = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 99) != 0);
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      b = 32'($urandom_range(0, 7));
      step(r, v, op, a, b);
      total++;
      if (io_rd !== m_rd) begin
        bad++;
        $display("FAIL random%0d got=0x%08h want=0x%08h", k, io_rd, m_rd);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_coef_load();
    test_hazard();
    test_fir_sequence();
    test_edge_cases();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scie_pipelined_fir.md
Name: scie_pipelined_fir

Overview:
- Pipelined custom-instruction functional unit attached to the core's SCIE (custom opcode) interface.
- Implements a 5-tap FIR filter with software-loaded coefficients, a sample delay line, and a registered result readout.
- Each valid instruction is decoded from its 7-bit major opcode. The unit has no stall or ready signalling: it accepts one instruction per cycle.

Parameters:
- XLEN, 32, data width of rs1, rs2, rd, coefficients, taps and accumulator
- NTAPS, 5, number of FIR taps and coefficients

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clock edge)
- io_valid  in  1  instruction valid this cycle
- io_insn  in  32  instruction word; only bits [6:0] (opcode) are decoded
- io_rs1  in  XLEN  source operand 1
- io_rs2  in  XLEN  source operand 2
- io_rd  out  XLEN  registered result

Behaviour:
- Reset (reset==0 at a rising edge) clears all state to 0: coef[0..4], tap[0..4], prod[0..4], and io_rd. io_rd reads 0 after reset.
- Decode: op = io_insn[6:0]. Bits [31:7] are ignored. Nothing happens when io_valid==0.
- Opcode 0x0B, SETCOEF (insn 11): if io_rs2 < NTAPS, then coef[io_rs2] <= io_rs1. Out-of-range indices are ignored. Taps, prod and io_rd are unaffected by the write itself.
- Opcode 0x2B, PUSH (insn 43): tap[0] <= io_rs1, and tap[i] <= tap[i-1] for i = 1..4. The oldest sample is dropped.
- Opcode 0x5B, READ (insn 91): io_rd <= sum over i of prod[i], truncated mod 2^XLEN.
- Any other opcode while valid is a no-op.
- Pipeline stage 1 updates every cycle: prod[i] <= low XLEN bits of (tap[i] * coef[i]), unsigned. It tracks tap and coef changes with one cycle of delay.
- Stage 2: io_rd is loaded only on READ and otherwise holds its value.
- Latency rules:
  - PUSH or SETCOEF accepted at edge t is reflected in prod at edge t+1.
  - A READ accepted at edge t+2 or later returns the updated sum; io_rd is valid after that edge.
  - A READ at edge t+1 returns the pre-update sum.
  - Software must leave at least one cycle between PUSH and READ.
- Arithmetic: all values are unsigned. Products and the sum wrap mod 2^32 with no saturation.
- Only one instruction per cycle, so there are no simultaneous-operation conflicts.
- Reset asserted mid-operation clears everything in the same edge, with priority over any valid instruction.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release it to 1. Expect io_rd=0. A READ with no other activity returns 0.
- Coefficient load, then first sample:
  - SETCOEF (rs1, rs2) = (33,0), (32,1), (57,2), (47,3), (94,4), one per cycle.
  - PUSH rs1=50, then one idle cycle, then READ.
  - Expect io_rd=1650 after the READ edge.
- FIR sequence: with the same coefficients, run PUSH, idle, READ for samples 92, 58, 64, 40 in order. Expect io_rd = 4636, 7708, 11562, 15698.
- Hazard: PUSH 92 immediately followed by READ (no idle cycle). Expect the pre-update sum of 1650. A READ one cycle later returns 4636. Without a READ, io_rd holds its value across idle cycles.
- Edge cases:
  - SETCOEF with rs2=7 changes nothing.
  - An opcode of 0x7B with valid=1 changes nothing.
  - Large operands wrap mod 2^32: coef0=0xFFFFFFFF with sample 2 gives 0xFFFFFFFE.
- Mid-operation reset: after the FIR sequence, assert reset for 1 cycle. Coefficients, taps and io_rd all read 0. A following PUSH 5, idle, READ returns 0.
